nibble_serializer: RTL and testbench

//  Parallel-to-serial stage downstream of the 4-bit D-flip-flop register bank.

---
 rtl/nibser_pkg.sv | 13 +
 rtl/nibble_serializer_shift_reg_ld.sv | 30 +++
 rtl/nibble_serializer.sv | 119 +++++++++++
 tb/tb_nibble_serializer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/nibser_pkg.sv
// Shared types and constants for the nibble serializer.
// Build option: NIBSER_PARITY_EN appends an even parity beat to each word.
package nibser_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serializer_shift_reg_ld.sv
// Parallel-load shift register; head is the bit on the wire.
// Shift direction follows MSB_FIRST, vacated bits fill with 0.
module shift_reg_ld #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             head
);

    logic [WIDTH-1:0] q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            if (MSB_FIRST) q <= {q[WIDTH-2:0], 1'b0};
            else           q <= {1'b0, q[WIDTH-1:1]};
        end
    end

    assign head = MSB_FIRST ? q[WIDTH-1] : q[0];

endmodule

// File: rtl/nibble_serializer.sv
// Parallel-to-serial stage: one word in, one bit per accepted beat out.
// Build option: NIBSER_PARITY_EN adds a final even parity beat.
module nibble_serializer
    import nibser_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    state_t        state;
    logic [CW-1:0] count;
    logic          head;
    logic          accept;
    logic          beat;

    assign accept = (state == ST_IDLE) && in_valid && in_ready;
    assign beat   = ser_valid && ser_ready;

    shift_reg_ld #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_sreg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .shift ((state == ST_SHIFT) && beat),
        .din   (in_data),
        .head  (head)
    );

`ifdef NIBSER_PARITY_EN
    logic par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      par <= 1'b0;
        else if (accept) par <= ^in_data;
    end

    assign ser_out = (state == ST_PARITY) ? par : head;
`else
    assign ser_out = head;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            count     <= '0;
            in_ready  <= 1'b0;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state     <= ST_SHIFT;
                        count     <= '0;
                        in_ready  <= 1'b0;
                        ser_valid <= 1'b1;
                        ser_last  <= 1'b0;
                        busy      <= 1'b1;
                    end else begin
                        in_ready  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (beat) begin
                        count <= count + 1'b1;
                        if (count == LAST_IDX) begin
`ifdef NIBSER_PARITY_EN
                            state     <= ST_PARITY;
                            ser_last  <= 1'b1;
`else
                            state     <= ST_IDLE;
                            ser_valid <= 1'b0;
                            ser_last  <= 1'b0;
                            busy      <= 1'b0;
                            in_ready  <= 1'b1;
`endif
                        end else begin
`ifndef NIBSER_PARITY_EN
                            ser_last <= (count == LAST_IDX - 1'b1);
`endif
                        end
                    end
                end
`ifdef NIBSER_PARITY_EN
                ST_PARITY: begin
                    if (beat) begin
                        state     <= ST_IDLE;
                        ser_valid <= 1'b0;
                        ser_last  <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serializer.sv
// Directed bench for nibble_serializer, MSB-first and LSB-first instances.
// Expected beats are queued on capture and popped as beats complete.
module tb_nibble_serializer;

`ifdef NIBSER_PARITY_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    typedef struct {
        logic b;
        logic l;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in_data   [2];
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic       ser_out   [2];
    logic       ser_valid [2];
    logic       ser_ready [2];
    logic       ser_last  [2];
    logic       busy      [2];

    beat_t sb[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    nibble_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .ser_out(ser_out[0]), .ser_valid(ser_valid[0]), .ser_ready(ser_ready[0]),
        .ser_last(ser_last[0]), .busy(busy[0])
    );

    nibble_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .ser_out(ser_out[1]), .ser_valid(ser_valid[1]), .ser_ready(ser_ready[1]),
        .ser_last(ser_last[1]), .busy(busy[1])
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic push(input int s, input logic [3:0] data);
        beat_t e;
        for (int i = 0; i < 4; i++) begin
            e.b = (s == 0) ? data[3 - i] : data[i];
            e.l = (NB == 4) && (i == 3);
            sb.push_back(e);
        end
`ifdef NIBSER_PARITY_EN
        e.b = ^data;
        e.l = 1'b1;
        sb.push_back(e);
`endif
    endtask

    task automatic send(input int s, input logic [3:0] data,
                        input int stall_at, input int stall_len,
                        input bit junk);
        int n = 0;
        int stall = stall_len;
        int cyc = 0;
        chk("idle_in_ready", in_ready[s], 1'b1);
        chk("idle_busy", busy[s], 1'b0);
        in_valid[s] = 1'b1;
        in_data[s]  = data;
        push(s, data);
        @(negedge clk);
        in_valid[s] = junk;
        if (junk) in_data[s] = 4'hF;
        chk("accept_in_ready", in_ready[s], 1'b0);
        chk("accept_busy", busy[s], 1'b1);
        while (sb.size() > 0 && cyc < 40) begin
            chk("beat_valid", ser_valid[s], 1'b1);
            chk("beat_out", ser_out[s], sb[0].b);
            chk("beat_last", ser_last[s], sb[0].l);
            if (n == stall_at && stall > 0) begin
                ser_ready[s] = 1'b0;
                stall--;
            end else begin
                ser_ready[s] = 1'b1;
                void'(sb.pop_front());
                n++;
                if (sb.size() == 0) in_valid[s] = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        chk("all_beats_done", sb.size() == 0, 1'b1);
        sb.delete();
        ser_ready[s] = 1'b0;
        in_valid[s]  = 1'b0;
        chk("bubble_valid", ser_valid[s], 1'b0);
        chk("bubble_in_ready", in_ready[s], 1'b1);
        chk("bubble_busy", busy[s], 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            in_data[s]   = 4'h0;
            in_valid[s]  = 1'b0;
            ser_ready[s] = 1'b0;
        end
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("rst_in_ready", in_ready[s], 1'b0);
            chk("rst_valid", ser_valid[s], 1'b0);
            chk("rst_out", ser_out[s], 1'b0);
            chk("rst_last", ser_last[s], 1'b0);
            chk("rst_busy", busy[s], 1'b0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready_m", in_ready[0], 1'b1);
        chk("rel_in_ready_l", in_ready[1], 1'b1);

        send(0, 4'b1011, -1, 0, 1'b0);
        send(1, 4'b1011, -1, 0, 1'b0);
        send(0, 4'b1011, 1, 3, 1'b0);
        send(0, 4'b0001, -1, 0, 1'b1);
        send(1, 4'b0110, 2, 2, 1'b1);

        in_valid[0] = 1'b1;
        in_data[0]  = 4'b1011;
        @(negedge clk);
        in_valid[0]  = 1'b0;
        ser_ready[0] = 1'b1;
        chk("mid_b1", ser_out[0], 1'b1);
        @(negedge clk);
        ser_ready[0] = 1'b0;
        chk("mid_b2", ser_out[0], 1'b0);
        chk("mid_valid", ser_valid[0], 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", ser_valid[0], 1'b0);
        chk("mrst_busy", busy[0], 1'b0);
        chk("mrst_in_ready", in_ready[0], 1'b0);
        chk("mrst_last", ser_last[0], 1'b0);
        chk("mrst_out", ser_out[0], 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready_low", in_ready[0], 1'b0);
        @(negedge clk);
        chk("rel_in_ready", in_ready[0], 1'b1);
        chk("rel_no_residue", ser_valid[0], 1'b0);
        send(0, 4'b0110, -1, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
